dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 11 +
 rtl/dmem_array.sv | 22 ++
 rtl/dmem_responder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared sizing and FSM encoding for the data-memory responder.
package dmem_responder_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 256;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_LOAD     = 2'd1;
    localparam logic [1:0] ST_DUMP_RD  = 2'd2;
    localparam logic [1:0] ST_DUMP_OUT = 2'd3;
endpackage

// File: rtl/dmem_array.sv
// Single shared-port synchronous RAM; read data is registered and held between reads.
module dmem_array #(
    parameter int ADDR_W = dmem_responder_pkg::ADDR_W,
    parameter int DATA_W = dmem_responder_pkg::DATA_W,
    parameter int DEPTH  = dmem_responder_pkg::DEPTH
) (
    input  logic              Clock,
    input  logic              en,
    input  logic              we,
    input  logic [0:ADDR_W-1] addr,
    input  logic [0:DATA_W-1] wdata,
    output logic [0:DATA_W-1] rdata
);
    logic [0:DATA_W-1] mem [DEPTH];

    always_ff @(posedge Clock) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// Processor data memory with a preload/readback burst engine; bursts own the RAM port
// and processor accesses that arrive meanwhile are dropped and counted.
module dmem_responder #(
    parameter int ADDR_W = dmem_responder_pkg::ADDR_W,
    parameter int DATA_W = dmem_responder_pkg::DATA_W,
    parameter int DEPTH  = dmem_responder_pkg::DEPTH
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [0:ADDR_W-1] Mem_Addr,
    input  logic [0:DATA_W-1] Data_In,
    input  logic              DmemEn,
    input  logic              DmemWrEn,
    output logic [0:DATA_W-1] Data_Out,
    input  logic              Init_Start,
    input  logic [0:ADDR_W-1] Init_Base,
    input  logic [0:ADDR_W]   Init_Count,
    input  logic              Init_Valid,
    input  logic [0:DATA_W-1] Init_Data,
    output logic              Init_Ready,
    input  logic              Dump_Start,
    input  logic [0:ADDR_W-1] Dump_Base,
    input  logic [0:ADDR_W]   Dump_Count,
    output logic              Dump_Valid,
    output logic [0:DATA_W-1] Dump_Data,
    input  logic              Dump_Ready,
    output logic              Busy,
    output logic              Done,
    output logic [0:7]        Conflict_Cnt
);
    import dmem_responder_pkg::*;

    logic [1:0]        state;
    logic [0:ADDR_W-1] ptr;
    logic [0:ADDR_W]   rem;
    logic              ram_en, ram_we;
    logic [0:ADDR_W-1] ram_addr;
    logic [0:DATA_W-1] ram_wdata, ram_q;
    logic [0:DATA_W-1] dout_r;
    logic              dout_from_ram;
    logic              proc_drop, proc_rd, last_beat;

    assign Busy       = (state != ST_IDLE);
    assign Init_Ready = (state == ST_LOAD);
    assign Dump_Valid = (state == ST_DUMP_OUT);
    assign Dump_Data  = Dump_Valid ? ram_q : '0;
    assign proc_drop  = DmemEn && Busy;
    assign proc_rd    = DmemEn && !DmemWrEn && !Busy;
    assign last_beat  = (rem == (ADDR_W+1)'(1));
    // The RAM output register doubles as Data_Out until a dump read would overwrite it.
    assign Data_Out   = dout_from_ram ? ram_q : dout_r;

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = ptr;
        ram_wdata = Init_Data;
        case (state)
            ST_IDLE: begin
                ram_en    = DmemEn;
                ram_we    = DmemWrEn;
                ram_addr  = Mem_Addr;
                ram_wdata = Data_In;
            end
            ST_LOAD: begin
                ram_en = Init_Valid;
                ram_we = 1'b1;
            end
            ST_DUMP_RD: ram_en = 1'b1;
            default: ;
        endcase
    end

    dmem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
        .Clock (Clock),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_q)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            rem           <= '0;
            Done          <= 1'b0;
            Conflict_Cnt  <= '0;
            dout_r        <= '0;
            dout_from_ram <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Init_Start wins a simultaneous request even if its count is zero.
                    if (Init_Start) begin
                        if (Init_Count != '0) begin
                            state <= ST_LOAD;
                            ptr   <= Init_Base;
                            rem   <= Init_Count;
                        end
                    end else if (Dump_Start && Dump_Count != '0) begin
                        state <= ST_DUMP_RD;
                        ptr   <= Dump_Base;
                        rem   <= Dump_Count;
                    end
                end
                ST_LOAD: if (Init_Valid) begin
                    ptr <= ptr + 1'b1;
                    rem <= rem - 1'b1;
                    if (last_beat) begin
                        state <= ST_IDLE;
                        Done  <= 1'b1;
                    end
                end
                ST_DUMP_RD: state <= ST_DUMP_OUT;
                default: if (Dump_Ready) begin
                    ptr <= ptr + 1'b1;
                    rem <= rem - 1'b1;
                    if (last_beat) begin
                        state <= ST_IDLE;
                        Done  <= 1'b1;
                    end else begin
                        state <= ST_DUMP_RD;
                    end
                end
            endcase

            if (proc_drop) begin
                dout_r        <= '0;
                dout_from_ram <= 1'b0;
            end else if (proc_rd) begin
                dout_from_ram <= 1'b1;
            end else if (state == ST_DUMP_RD && dout_from_ram) begin
                dout_r        <= ram_q;
                dout_from_ram <= 1'b0;
            end

            if (proc_drop && Conflict_Cnt != '1)
                Conflict_Cnt <= Conflict_Cnt + 1'b1;
        end
    end
endmodule
